seat_lookup: RTL and testbench
==============================

Name: seat_lookup

Overview:
- Read-side companion to the seat table write port.
- Given a student number, scans the 32-entry seat table through a synchronous read port and returns the lowest seat holding that number.
- Entry value 0 means an empty seat, so a query of 0 returns the first free seat. Seat assignment and display logic use this.
- Scan is pipelined: one read issued per cycle, with compare one cycle behind.

Parameters:
- SEATS, 32, number of table entries; must be a power of two and at least 2.
- SEAT_W, 5, seat index width; equals log2(SEATS).
- ID_W, 32, student number width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  query request; sampled only in IDLE
- query_id  in  ID_W  student number to find; captured on the accepted start
- rd_en  out  1  table read strobe (registered)
- rd_addr  out  SEAT_W  table read address (registered)
- rd_data  in  ID_W  table data; valid the cycle after the rd_en/rd_addr cycle
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the result is valid
- found  out  1  1 = match; held until the next accepted start
- seat_no  out  SEAT_W  matching seat index (0 when not found); held until the next accepted start

Behaviour:
- Reset (asynchronous, any state): state=IDLE, and rd_en, rd_addr, busy, done, found, seat_no, the captured query and the compare pipeline all go to 0. A reset mid-scan aborts with no done pulse.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - done=0.
  - On an edge with start=1: capture query_id; rd_en<=1; rd_addr<=0; busy<=1; found<=0; seat_no<=0; go to SCAN.
- SCAN:
  - Each edge: the compare stage samples rd_data against the captured query for the address issued in the previous cycle, if that cycle had rd_en=1.
  - If rd_addr < SEATS-1, rd_addr increments.
  - If rd_addr = SEATS-1, rd_en<=0 and the state goes to DRAIN.
- DRAIN: waits for the last compare, then ends the scan.
- Match at any compare:
  - found<=1; seat_no<=compared address; done<=1; busy<=0; rd_en<=0.
  - State goes to IDLE and the in-flight read is discarded.
  - The lowest index always wins.
- Compare of address SEATS-1 with no match: found<=0; seat_no<=0; done<=1; busy<=0; state goes to IDLE.
- Latency (start sampled at edge E0):
  - Match at seat k: done is high in the cycle after edge E(k+2).
  - Miss: done is high after edge E(SEATS+1), i.e. E33 for the defaults.
- rd_addr never wraps. Exactly one pass runs per query, with at most SEATS reads.
- start while busy, or in the done cycle's originating edge, is ignored. A start in the cycle where done=1 (state already IDLE) is accepted.
- query_id changes after acceptance have no effect.
- No arithmetic beyond the SEAT_W-bit increment. Compares are a full ID_W-bit equality.

Test Plan:
- Table seat 7 = 20231234, others 0; start with query 20231234 -> rd_addr 0..8 issued, done after E9, found=1, seat_no=7, busy low in the same cycle.
- Table all nonzero, none equal to 5; query 5 -> 32 reads (0..31), done after E33, found=0, seat_no=0, rd_en low afterwards.
- Duplicate id 42 at seats 3 and 19 -> found=1, seat_no=3, reads stop after addr 4 and no read of 19 occurs; results hold at 1/3 for 10 idle cycles.
- Query 0 with seats 0..9 occupied -> seat_no=10, found=1; with all 32 occupied -> found=0.
- start pulsed at cycle 4 of a scan and query_id changed mid-scan -> ignored, and the original result is returned. Back-to-back start in the done cycle -> second query accepted, found/seat_no cleared the next cycle.
- reset asserted asynchronously at scan address 12 -> all outputs 0 immediately, no done pulse; a new start after reset runs a full correct scan.

Source files
------------

// File: rtl/seat_lookup.sv
// Seat table lookup: scans the table through a synchronous read port and
// reports the lowest seat whose entry equals the query (0 queries the first free seat).
module seat_lookup #(
  parameter int SEATS  = 32,
  parameter int SEAT_W = 5,
  parameter int ID_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ID_W-1:0]   query_id,
  output logic              rd_en,
  output logic [SEAT_W-1:0] rd_addr,
  input  logic [ID_W-1:0]   rd_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [SEAT_W-1:0] seat_no
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(SEATS - 1);

  state_t            state_r, state_s;
  logic [ID_W-1:0]   query_r, query_s;
  logic              rd_en_r, rd_en_s;
  logic [SEAT_W-1:0] rd_addr_r, rd_addr_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              found_r, found_s;
  logic [SEAT_W-1:0] seat_no_r, seat_no_s;
  // compare stage: address whose data is on rd_data this cycle
  logic              cmp_valid_r, cmp_valid_s;
  logic [SEAT_W-1:0] cmp_addr_r, cmp_addr_s;
  logic              match_s;

  assign match_s = cmp_valid_r && (rd_data == query_r);

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      query_r     <= '0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      found_r     <= 1'b0;
      seat_no_r   <= '0;
      cmp_valid_r <= 1'b0;
      cmp_addr_r  <= '0;
    end else begin
      state_r     <= state_s;
      query_r     <= query_s;
      rd_en_r     <= rd_en_s;
      rd_addr_r   <= rd_addr_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      found_r     <= found_s;
      seat_no_r   <= seat_no_s;
      cmp_valid_r <= cmp_valid_s;
      cmp_addr_r  <= cmp_addr_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (match_s) begin
          state_s = IDLE;
        end else if (rd_addr_r == LAST_SEAT) begin
          state_s = DRAIN;
        end else begin
          state_s = SCAN;
        end
      end
      DRAIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and compare pipeline
  always_comb begin
    query_s     = query_r;
    rd_en_s     = rd_en_r;
    rd_addr_s   = rd_addr_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    found_s     = found_r;
    seat_no_s   = seat_no_r;
    cmp_valid_s = 1'b0;
    cmp_addr_s  = rd_addr_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          query_s   = query_id;
          rd_en_s   = 1'b1;
          rd_addr_s = '0;
          busy_s    = 1'b1;
          found_s   = 1'b0;
          seat_no_s = '0;
        end else begin
          rd_en_s   = 1'b0;
        end
      end
      SCAN: begin
        if (match_s) begin
          // the read issued this cycle is dropped; a lower seat already matched
          found_s   = 1'b1;
          seat_no_s = cmp_addr_r;
          done_s    = 1'b1;
          busy_s    = 1'b0;
          rd_en_s   = 1'b0;
        end else if (rd_addr_r == LAST_SEAT) begin
          rd_en_s     = 1'b0;
          cmp_valid_s = rd_en_r;
        end else begin
          rd_addr_s   = rd_addr_r + SEAT_W'(1);
          cmp_valid_s = rd_en_r;
        end
      end
      DRAIN: begin
        // only the last seat's compare is outstanding here
        found_s   = match_s;
        seat_no_s = match_s ? cmp_addr_r : '0;
        done_s    = 1'b1;
        busy_s    = 1'b0;
        rd_en_s   = 1'b0;
      end
      default: begin
        rd_en_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign rd_en   = rd_en_r;
  assign rd_addr = rd_addr_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign found   = found_r;
  assign seat_no = seat_no_r;

endmodule

// File: tb/tb_seat_lookup.sv
// Bench for seat_lookup: table-driven queries against a model seat table,
// with a scoreboard of expected results and timing, plus corner-case sequences.
module tb_seat_lookup;
  localparam int SEATS  = 32;
  localparam int SEAT_W = 5;
  localparam int ID_W   = 32;

  typedef struct {
    int              base;   // 0: empty table, 1: every seat occupied
    int              occ_n;  // with base 0, seats 0..occ_n-1 occupied
    int              p1;
    logic [ID_W-1:0] v1;
    int              p2;
    logic [ID_W-1:0] v2;
    logic [ID_W-1:0] query;
    logic            exp_found;
    logic [SEAT_W-1:0] exp_seat;
  } vec_t;

  typedef struct {
    logic              f;
    logic [SEAT_W-1:0] s;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start;
  logic [ID_W-1:0] query_id, rd_data;
  logic rd_en, busy, done, found;
  logic [SEAT_W-1:0] rd_addr, seat_no;

  logic [ID_W-1:0] tbl [SEATS];
  int   tests = 0, fails = 0;
  int   cycle_cnt = 0, done_cnt = 0, exp_dones = 0;
  int   rd_log[$];
  exp_t sb[$];
  vec_t vecs[8];

  seat_lookup #(.SEATS(SEATS), .SEAT_W(SEAT_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .start(start), .query_id(query_id),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .found(found), .seat_no(seat_no)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // synchronous-read seat table
  always @(posedge clk) begin
    if (rd_en) rd_data <= tbl[rd_addr];
  end

  always @(negedge clk) begin
    if (rd_en) rd_log.push_back(int'(rd_addr));
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic f, input logic [SEAT_W-1:0] s);
    return f ? int'(s) + 2 : SEATS + 1;
  endfunction

  function automatic int exp_reads(input logic f, input logic [SEAT_W-1:0] s);
    if (!f) return SEATS;
    return (int'(s) + 2 > SEATS) ? SEATS : int'(s) + 2;
  endfunction

  task automatic load_table(input vec_t v);
    for (int i = 0; i < SEATS; i++) begin
      if (v.base == 1 || i < v.occ_n) tbl[i] = ID_W'(i + 100);
      else tbl[i] = '0;
    end
    if (v.p1 >= 0) tbl[v.p1] = v.v1;
    if (v.p2 >= 0) tbl[v.p2] = v.v2;
  endtask

  // caller positions at a negedge; returns #1 after the accepting edge
  task automatic start_query(input logic [ID_W-1:0] q, input logic f, input logic [SEAT_W-1:0] s);
    start = 1'b1;
    query_id = q;
    @(posedge clk);
    #1;
    sb.push_back('{f, s, cycle_cnt + exp_lat(f, s)});
    exp_dones++;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic got;
    exp_t e;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, got, 1);
    if (got) begin
      if (sb.size() == 0) begin
        check({name, "_scoreboard_entry"}, 0, 1);
      end else begin
        e = sb.pop_front();
        check({name, "_found"}, found, e.f);
        check({name, "_seat_no"}, seat_no, e.s);
        check({name, "_latency_cycle"}, cycle_cnt, e.due);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_rd_en_at_done"}, rd_en, 0);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int base, n;
    logic ok;
    load_table(v);
    @(negedge clk);
    base = rd_log.size();
    start_query(v.query, v.exp_found, v.exp_seat);
    wait_done(name);
    n = rd_log.size() - base;
    check({name, "_read_count"}, n, exp_reads(v.exp_found, v.exp_seat));
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (rd_log[base + i] != i) ok = 1'b0;
    end
    check({name, "_read_order"}, ok, 1);
  endtask

  initial begin
    int hold_ok, dc;
    vecs[0] = '{0, 0,  7, 32'd20231234,  -1, 32'd0,  32'd20231234,  1'b1, 5'd7};
    vecs[1] = '{1, 0, -1, 32'd0,         -1, 32'd0,  32'd5,         1'b0, 5'd0};
    vecs[2] = '{1, 0,  3, 32'd42,        19, 32'd42, 32'd42,        1'b1, 5'd3};
    vecs[3] = '{0, 10, -1, 32'd0,        -1, 32'd0,  32'd0,         1'b1, 5'd10};
    vecs[4] = '{1, 0, -1, 32'd0,         -1, 32'd0,  32'd0,         1'b0, 5'd0};
    vecs[5] = '{1, 0,  0, 32'hDEADBEEF,  -1, 32'd0,  32'hDEADBEEF,  1'b1, 5'd0};
    vecs[6] = '{1, 0, 31, 32'hCAFEF00D,  -1, 32'd0,  32'hCAFEF00D,  1'b1, 5'd31};
    vecs[7] = '{1, 0, 30, 32'h80000001,  -1, 32'd0,  32'h00000001,  1'b0, 5'd0};

    reset = 1'b1;
    start = 1'b0;
    query_id = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rd_en, rd_addr, busy, done, found, seat_no}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {rd_en, rd_addr, busy, done, found, seat_no}, 0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 2) begin
        hold_ok = 1;
        repeat (10) begin
          @(negedge clk);
          if (found !== 1'b1 || seat_no !== 5'd3 || done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0)
            hold_ok = 0;
        end
        check("dup_result_hold", hold_ok, 1);
      end
    end

    // start pulse and query_id change during a scan are ignored
    load_table(vecs[0]);
    @(negedge clk);
    start_query(32'd20231234, 1'b1, 5'd7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    query_id = 32'd0;
    @(negedge clk);
    start = 1'b0;
    query_id = 32'd999;
    wait_done("midscan_start");

    // back-to-back: start in the done cycle is accepted
    @(negedge clk);
    start_query(32'd20231234, 1'b1, 5'd7);
    wait_done("b2b_first");
    start_query(32'd77777, 1'b0, 5'd0);
    @(negedge clk);
    check("b2b_found_cleared", found, 0);
    check("b2b_busy", busy, 1);
    wait_done("b2b_second");

    // asynchronous reset mid-scan
    load_table(vecs[1]);
    @(negedge clk);
    start_query(32'd5, 1'b0, 5'd0);
    hold_ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd_addr == 5'd12) begin
        hold_ok = 1;
        break;
      end
    end
    check("reset_reached_addr12", hold_ok, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {rd_en, rd_addr, busy, done, found, seat_no}, 0);
    sb.delete();
    exp_dones--;
    dc = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_reset", done_cnt, dc);
    run_vec(vecs[2], "after_reset");

    repeat (5) @(negedge clk);
    check("total_done_pulses", done_cnt, exp_dones);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
